// File: rtl/stream_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_arb_pkg
// Description : Shared types and helpers for the stream round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================

package stream_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Index of the requester after idx, wrapping back to 0 past n-1.
  function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Finds the first set request at or above start_ptr, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================

module rr_priority_picker #(
  parameter int NUM_IN   = 4,
  parameter int ID_WIDTH = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN-1:0]   req,
  input  logic [ID_WIDTH-1:0] start_ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] winner
);

  // Walk offsets from the farthest down so the nearest hit is written last.
  always_comb begin
    logic [ID_WIDTH:0]   sum;
    logic [ID_WIDTH-1:0] idx;
    sum    = '0;
    idx    = '0;
    found  = 1'b0;
    winner = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      sum = {1'b0, start_ptr} + (ID_WIDTH + 1)'(k);
      if (sum >= (ID_WIDTH + 1)'(NUM_IN)) begin
        sum = sum - (ID_WIDTH + 1)'(NUM_IN);
      end
      idx = sum[ID_WIDTH-1:0];
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : stream_rr_arbiter
// Description : Burst-locked round-robin arbiter feeding one registered stream.
// Revision    : 1.0 - initial release
// ============================================================================

module stream_rr_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_IN-1:0]            data_in_valid,
  input  logic [NUM_IN-1:0]            data_in_last,
  output logic [NUM_IN-1:0]            data_in_ready,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_out_valid,
  output logic                         data_out_last,
  output logic [ID_WIDTH-1:0]          data_out_id,
  input  logic                         data_out_ready
);

  import stream_arb_pkg::*;

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  dout_last_q, dout_last_d;
  logic [ID_WIDTH-1:0]   dout_id_q, dout_id_d;

  logic [DATA_WIDTH-1:0] req_data [NUM_IN];
  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_id;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  slot_free;
  logic                  accept;
  logic                  burst_end;

  generate
    for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
      assign req_data[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_priority_picker #(
    .NUM_IN   (NUM_IN),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req       (data_in_valid),
    .start_ptr (rr_ptr_q),
    .found     (pick_found),
    .winner    (pick_id)
  );

  assign sel_valid = data_in_valid[grant_id_q];
  assign sel_last  = data_in_last[grant_id_q];
  assign sel_data  = req_data[grant_id_q];

  // The output stage can take a beat if it is empty or draining this cycle.
  assign slot_free = !dout_valid_q || data_out_ready;
  assign accept    = (state_q == LOCK) && sel_valid && slot_free;
  assign burst_end = accept && (sel_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      dout_id_q    <= dout_id_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    beat_cnt_d   = beat_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    dout_id_d    = dout_id_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = LOCK;
          grant_id_d = pick_id;
          beat_cnt_d = '0;
        end
      end
      LOCK: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        if (burst_end) begin
          state_d  = IDLE;
          rr_ptr_d = ID_WIDTH'(wrap_next(32'(grant_id_q), NUM_IN));
        end
      end
      default: state_d = IDLE;
    endcase

    // A new accept takes precedence over draining, so valid stays up on reload.
    if (accept) begin
      dout_d       = sel_data;
      dout_id_d    = grant_id_q;
      dout_last_d  = burst_end;
      dout_valid_d = 1'b1;
    end else if (data_out_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_comb begin
    data_in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      data_in_ready[i] = (state_q == LOCK) && (grant_id_q == ID_WIDTH'(i)) && slot_free;
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = dout_valid_q;
  assign data_out_last  = dout_last_q;
  assign data_out_id    = dout_id_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_rr_arbiter
// Description : Directed and random checks of stream_rr_arbiter against a model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_stream_rr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MB  = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    data_in_valid;
  logic [N-1:0]    data_in_last;
  logic [N-1:0]    data_in_ready;
  logic [DW-1:0]   data_out;
  logic            data_out_valid;
  logic            data_out_last;
  logic [IDW-1:0]  data_out_id;
  logic            data_out_ready;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  always #5 clk = ~clk;

  stream_rr_arbiter #(
    .NUM_IN     (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_last   (data_in_last),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_last  (data_out_last),
    .data_out_id    (data_out_id),
    .data_out_ready (data_out_ready)
  );

  // Per-requester pending beats {last, data}; the head is what is presented.
  logic [DW:0]     src_q [N][$];
  logic [N-1:0]    en;

  // Reference model: who owns the sink, where the next search starts, output slot.
  bit              m_busy;
  int              m_owner, m_ptr, m_beats, m_oid;
  bit              m_ov, m_olast;
  logic [DW-1:0]   m_od;

  logic [IDW+DW:0] hs_log[$];
  logic            prev_v;
  logic [IDW+DW:0] prev_beat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
    m_ov = 0; m_olast = 0; m_od = '0; m_oid = 0;
  endtask

  task automatic model_edge();
    bit acc;
    int o;
    logic [DW:0] b;
    acc = 0;
    if (rst && prev_v && data_out_ready) hs_log.push_back(prev_beat);
    if (!rst) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        o = (m_ptr + k) % N;
        if (data_in_valid[o]) begin
          m_busy = 1; m_owner = o; m_beats = 0;
          break;
        end
      end
    end else if (data_in_valid[m_owner] && (!m_ov || data_out_ready)) begin
      acc = 1;
    end
    if (acc) begin
      b = src_q[m_owner].pop_front();
      m_beats++;
      m_ov = 1; m_od = b[DW-1:0]; m_oid = m_owner;
      m_olast = b[DW] || (m_beats == MB);
      if (m_olast) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % N;
      end
    end else if (data_out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        data_in_valid[i]      = 1'b1;
        data_in[i*DW +: DW]   = src_q[i][0][DW-1:0];
        data_in_last[i]       = src_q[i][0][DW];
      end else begin
        data_in_valid[i]      = 1'b0;
        data_in_last[i]       = 1'(DW'($urandom) & 1);
        data_in[i*DW +: DW]   = DW'($urandom);
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] er;
    er = '0;
    for (int i = 0; i < N; i++) er[i] = m_busy && (i == m_owner) && (!m_ov || data_out_ready);
    chk({phase, ":ready"}, 64'(data_in_ready), 64'(er));
    chk({phase, ":valid"}, 64'(data_out_valid), 64'(m_ov));
    if (m_ov || !rst)
      chk({phase, ":beat"}, 64'({data_out_id, data_out_last, data_out}),
          64'({IDW'(m_oid), m_olast, m_od}));
    prev_v    = data_out_valid;
    prev_beat = {data_out_id, data_out_last, data_out};
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    apply_inputs();
    @(negedge clk);
    compare();
  endtask

  task automatic push_burst(input int r, input int len, input logic [DW-1:0] base);
    for (int j = 0; j < len; j++) src_q[r].push_back({j == len - 1, base + DW'(j)});
  endtask

  function automatic bit pending();
    bit p;
    p = m_ov || m_busy;
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) p = 1;
    return p;
  endfunction

  initial begin
    logic [DW-1:0]  sdata;
    logic [IDW-1:0] sid;
    int guard;
    data_in = '0; data_in_valid = '0; data_in_last = '0;
    data_out_ready = 1'b1; en = '0; rst = 1'b0;
    model_reset(); prev_v = 0; prev_beat = '0;
    sdata = '0; sid = '0;

    phase = "reset";
    repeat (2) tick();
    chk("reset_outputs", 64'({data_out_valid, data_out_last, data_out_id, data_out}), 64'(0));
    rst = 1'b1;
    tick();

    // Single requester, three beats, last on the third.
    phase = "single"; hs_log.delete();
    push_burst(1, 3, 8'h11);
    src_q[1].delete();
    src_q[1].push_back({1'b0, 8'h11});
    src_q[1].push_back({1'b0, 8'h22});
    src_q[1].push_back({1'b1, 8'h33});
    en = 4'b0010;
    tick();
    chk("single_c0_ready", 64'(data_in_ready), 64'(0));
    tick();
    chk("single_c1_ready", 64'(data_in_ready), 64'(4'b0010));
    tick();
    chk("single_c2_out", 64'({data_out_valid, data_out_id, data_out}), 64'({1'b1, 2'd1, 8'h11}));
    repeat (6) tick();
    chk("single_log_n", 64'(hs_log.size()), 64'(3));
    if (hs_log.size() == 3) begin
      chk("single_log0", 64'(hs_log[0]), 64'({2'd1, 1'b0, 8'h11}));
      chk("single_log1", 64'(hs_log[1]), 64'({2'd1, 1'b0, 8'h22}));
      chk("single_log2", 64'(hs_log[2]), 64'({2'd1, 1'b1, 8'h33}));
    end

    // Requester 0 never flags last for four beats: the cap closes the burst.
    phase = "cap"; hs_log.delete();
    for (int j = 0; j < 5; j++) src_q[0].push_back({j == 4, 8'hA0 + 8'(j)});
    en = 4'b0001;
    repeat (14) tick();
    chk("cap_log_n", 64'(hs_log.size()), 64'(5));
    if (hs_log.size() == 5) begin
      chk("cap_beat2_nolast", 64'(hs_log[2]), 64'({2'd0, 1'b0, 8'hA2}));
      chk("cap_beat3_last",   64'(hs_log[3]), 64'({2'd0, 1'b1, 8'hA3}));
      chk("cap_beat4_last",   64'(hs_log[4]), 64'({2'd0, 1'b1, 8'hA4}));
    end

    // Downstream stalls for five cycles mid-burst.
    phase = "backpressure"; hs_log.delete();
    push_burst(3, 4, 8'hB0);
    en = 4'b1000;
    guard = 0;
    while (hs_log.size() < 1 && guard < 20) begin tick(); guard++; end
    chk("bp_first_beat_seen", 64'(hs_log.size() >= 1), 64'(1));
    data_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_ready3_low", 64'(data_in_ready[3]), 64'(0));
      if (k == 0) begin
        sdata = data_out; sid = data_out_id;
      end else begin
        chk("bp_hold", 64'({data_out_valid, data_out_id, data_out}), 64'({1'b1, sid, sdata}));
      end
    end
    data_out_ready = 1'b1;
    repeat (8) tick();
    chk("bp_log_n", 64'(hs_log.size()), 64'(4));
    if (hs_log.size() == 4)
      for (int j = 0; j < 4; j++)
        chk("bp_log", 64'(hs_log[j]), 64'({2'd3, j == 3, 8'hB0 + 8'(j)}));

    // Granted requester 2 goes quiet mid-burst while requester 3 waits.
    phase = "stall"; hs_log.delete();
    push_burst(2, 3, 8'hC0);
    push_burst(3, 1, 8'hD0);
    en = 4'b1100;
    guard = 0;
    while (src_q[2].size() > 2 && guard < 20) begin tick(); guard++; end
    en = 4'b1000;
    repeat (3) begin
      tick();
      chk("stall_ready3_low", 64'(data_in_ready[3]), 64'(0));
    end
    en = 4'b1100;
    repeat (10) tick();
    chk("stall_log_n", 64'(hs_log.size()), 64'(4));
    if (hs_log.size() == 4) begin
      chk("stall_log2", 64'(hs_log[2]), 64'({2'd2, 1'b1, 8'hC2}));
      chk("stall_log3", 64'(hs_log[3]), 64'({2'd3, 1'b1, 8'hD0}));
    end

    // Reset with a beat held in the output register; arbitration restarts at 0.
    phase = "midreset"; hs_log.delete();
    push_burst(2, 1, 8'h50);
    en = 4'b0100;
    repeat (5) tick();
    push_burst(3, 4, 8'hF0);
    push_burst(1, 1, 8'h60);
    en = 4'b1000;
    data_out_ready = 1'b0;
    repeat (4) tick();
    chk("midreset_held", 64'(data_out_valid), 64'(1));
    rst = 1'b0;
    #1;
    model_reset();
    compare();
    chk("midreset_async_zero",
        64'({data_in_ready, data_out_valid, data_out_last, data_out_id, data_out}), 64'(0));
    en = 4'b1010;
    repeat (2) tick();
    data_out_ready = 1'b1;
    rst = 1'b1;
    tick();
    chk("midreset_regrant_req1", 64'(data_in_ready), 64'(4'b0010));
    repeat (12) tick();

    // Random traffic, enables and downstream readiness.
    phase = "random";
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() < 2 && $urandom_range(0, 3) == 0)
          push_burst(i, $urandom_range(1, 6), DW'($urandom));
        en[i] = ($urandom_range(0, 3) != 0);
      end
      data_out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    phase = "drain";
    en = '1;
    data_out_ready = 1'b1;
    guard = 0;
    while (pending() && guard < 300) begin tick(); guard++; end
    chk("drain_done", 64'(pending()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin arbiter that shares one valid/ready stream sink, typically the write side of a `fifo` instance, between `NUM_IN` requesters. It grants one requester at a time and holds the grant for a burst, which ends on a `last` beat or after `MAX_BURST` beats. Granted data passes through a single registered output stage tagged with the source index. It sits in front of shared buffers where several producers feed one consumer.

## Interface
- `NUM_IN`, default 4: number of requesters. Must be ≥1.
- `DATA_WIDTH`, default 8: payload width.
- `MAX_BURST`, default 4: maximum beats per grant. Must be ≥1.
- `ID_WIDTH`, default `max(1,$clog2(NUM_IN))`: width of the source tag. Derived; do not override.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  asynchronous reset, active-low.
- `data_in`  in  `NUM_IN*DATA_WIDTH`  requester payloads; requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `data_in_valid`  in  `NUM_IN`  per-requester valid.
- `data_in_last`  in  `NUM_IN`  per-requester end-of-burst flag.
- `data_in_ready`  out  `NUM_IN`  per-requester ready; at most one bit high.
- `data_out`  out  `DATA_WIDTH`  registered payload.
- `data_out_valid`  out  1  output valid.
- `data_out_last`  out  1  high on the beat that closed the burst, whether by `last` or by the `MAX_BURST` cap.
- `data_out_id`  out  `ID_WIDTH`  index of the source of the current output beat.
- `data_out_ready`  in  1  downstream ready.

## Operation
- **States:** `IDLE` and `LOCK`.
- **`IDLE`:** pick the first requester with valid=1, searching from `rr_ptr` upward and wrapping. Register its index in `grant_id`, clear `beat_cnt`, and go to `LOCK`. If no requester is valid, stay in `IDLE`.
- **`LOCK`:**
  - `data_in_ready[grant_id] = !data_out_valid || data_out_ready`. All other ready bits are 0.
  - A beat is accepted when that requester's valid and ready are both 1.
  - On accept: the output register loads the payload, `data_out_id <= grant_id`, `beat_cnt` increments, and `data_out_valid <= 1`.
  - The burst ends when the accepted beat has `data_in_last=1`, or when `beat_cnt == MAX_BURST-1` at accept.
  - At burst end: set `data_out_last`, set `rr_ptr <= grant_id+1` (wrapping from `NUM_IN-1` to 0), and return to `IDLE`.
- **Output register:** `data_out_valid` clears on a cycle with `data_out_ready=1` and no new accept. Payload, id and last hold while valid=1 and ready=0.
- **Requester stall:** if the granted requester drops valid mid-burst, the grant is held indefinitely. There is no timeout and no pre-emption.
- **Other requesters** are ignored while in `LOCK`. Their payloads never reach the output.
- **`beat_cnt` width:** `$clog2(MAX_BURST+1)`. It never wraps.

## Timing
- **Reset values:** asserting `rst` low immediately forces:
  - state `IDLE`, `rr_ptr=0`, `grant_id=0`, `beat_cnt=0`
  - `data_out_valid=0`, `data_out_last=0`, `data_out_id=0`, `data_out=0`
  - all `data_in_ready=0`
- **Reset mid-burst:** any unread output beat is discarded. After release, arbitration restarts from requester 0.
- **Latency:**
  - Request valid in cycle 0 while `IDLE` → ready high in cycle 1.
  - A beat accepted in cycle 1 → `data_out_valid` high in cycle 2.
- **Throughput:** one beat per cycle while in `LOCK` with downstream ready. There is one `IDLE` bubble cycle between consecutive bursts.
- **Simultaneous events:**
  - Output drain and new accept in the same cycle: the register reloads and valid stays 1.
  - Burst end while the same requester is still valid: the next grant goes to the next valid index above it. The same requester is re-granted only if no other requester is valid.
- **Back-pressure:** with `data_out_ready=0` and `data_out_valid=1`, ready to the granted requester is 0. Nothing is dropped.
- **Edge cases:**
  - `NUM_IN=1`: the id is constant 0.
  - `MAX_BURST=1`: every beat is its own burst and carries `data_out_last=1`.

## Structure
- Package `stream_arb_pkg`: state enum typedef (`IDLE`, `LOCK`).
- Sub-module `rr_priority_picker`: combinational. Inputs are a request vector and a start pointer. Outputs are a `found` flag and the winner index.
- Top level holds the FSM, counters, `rr_ptr` and the output register.

## Test plan
- **Single requester burst:** req1 sends 3 beats 0x11, 0x22, 0x33 with last on 0x33; downstream always ready → output 0x11, 0x22, 0x33 with id=1, last only on 0x33, first output in cycle 2.
- **Burst cap:** req0 valid continuously, never asserts last, `MAX_BURST=4` → exactly 4 beats then release; `data_out_last` on the 4th beat; one `IDLE` cycle follows.
- **Fairness:** all 4 requesters valid continuously, each sending 1-beat bursts with last=1 → grant order 0, 1, 2, 3, 0, 1… and no requester is served twice before the others.
- **Back-pressure:** hold `data_out_ready=0` for 5 cycles mid-burst → `data_out` and `data_out_id` stable, granted ready=0, no beat lost or duplicated.
- **Requester stall:** granted req2 drops valid for 3 cycles mid-burst while req3 is valid → grant stays on 2 and req3 ready stays 0 until req2 finishes its burst.
- **Reset mid-operation:** pulse `rst` low during `LOCK` with a beat held in the output register → all outputs 0 during reset; after release, the first grant searches from requester 0.
